// File: rtl/spi_master.sv
// SPI frame master: 7-bit address, R/W bit, 8 data bits, MSB first; start/busy/done host side.
// Define SPI_MASTER_VERIFY_EN to follow every write with an automatic read-back and verify_err flag.
module spi_master #(
  parameter int CLK_DIV = 4,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              sclk_pin,
  output logic              cs_pin,
  output logic              mosi_pin,
  input  logic              miso_pin
`ifdef SPI_MASTER_VERIFY_EN
  ,
  output logic              verify_err
`endif
);

  localparam int FRAME_W = ADDR_W + 1 + DATA_W;
  localparam int CNT_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [4:0] BIT_LAST   = 5'(FRAME_W - 1);
  localparam logic [4:0] DATA_FIRST = 5'(ADDR_W + 1);

  if (CLK_DIV < 2) begin : g_bad_div
    $error("spi_master: CLK_DIV must be at least 2");
  end

  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, TAIL, GAP} state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [4:0]           bit_idx;
  logic [FRAME_W-1:0]   frame_q;
  logic [DATA_W-1:0]    rx;
  logic                 rw_q;
  logic                 cnt_last;

`ifdef SPI_MASTER_VERIFY_EN
  logic [ADDR_W-1:0]    addr_q;
  logic [DATA_W-1:0]    wdata_q;
  logic                 vfy_q;
`endif

  assign cnt_last = (cnt == CNT_LAST);

  // Read frames send zeros in the data phase.
  function automatic logic [FRAME_W-1:0] build_frame(input logic rd,
                                                     input logic [ADDR_W-1:0] a,
                                                     input logic [DATA_W-1:0] d);
    return {a, rd, rd ? {DATA_W{1'b0}} : d};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      frame_q  <= '0;
      rx       <= '0;
      rw_q     <= 1'b0;
      cs_pin   <= 1'b1;
      sclk_pin <= 1'b0;
      mosi_pin <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rdata    <= '0;
`ifdef SPI_MASTER_VERIFY_EN
      addr_q     <= '0;
      wdata_q    <= '0;
      vfy_q      <= 1'b0;
      verify_err <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rw_q     <= rw;
            frame_q  <= build_frame(rw, addr, wdata);
            mosi_pin <= addr[ADDR_W-1];
            cs_pin   <= 1'b0;
            busy     <= 1'b1;
            cnt      <= '0;
            state    <= SETUP;
`ifdef SPI_MASTER_VERIFY_EN
            addr_q     <= addr;
            wdata_q    <= wdata;
            vfy_q      <= 1'b0;
            verify_err <= 1'b0;
`endif
          end
        end
        SETUP: begin
          if (cnt_last) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= LOW;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LOW: begin
          if (cnt_last) begin
            cnt      <= '0;
            sclk_pin <= 1'b1;
            state    <= HIGH;
            // miso is captured on the same edge that raises sclk.
            if (rw_q && bit_idx >= DATA_FIRST) begin
              rx <= {rx[DATA_W-2:0], miso_pin};
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HIGH: begin
          if (cnt_last) begin
            cnt      <= '0;
            sclk_pin <= 1'b0;
            if (bit_idx == BIT_LAST) begin
              mosi_pin <= 1'b0;
              state    <= TAIL;
            end else begin
              bit_idx  <= bit_idx + 1'b1;
              mosi_pin <= frame_q[FRAME_W-2];
              frame_q  <= {frame_q[FRAME_W-2:0], 1'b0};
              state    <= LOW;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TAIL: begin
          if (cnt_last) begin
            cnt    <= '0;
            cs_pin <= 1'b1;
            state  <= GAP;
`ifdef SPI_MASTER_VERIFY_EN
            // The write half of a verified write completes silently.
            if (rw_q) begin
              done  <= 1'b1;
              rdata <= rx;
              if (vfy_q) begin
                verify_err <= (rx != wdata_q);
              end
            end
`else
            done <= 1'b1;
            if (rw_q) begin
              rdata <= rx;
            end
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt_last) begin
            cnt <= '0;
`ifdef SPI_MASTER_VERIFY_EN
            if (!rw_q) begin
              rw_q     <= 1'b1;
              vfy_q    <= 1'b1;
              frame_q  <= build_frame(1'b1, addr_q, wdata_q);
              mosi_pin <= addr_q[ADDR_W-1];
              cs_pin   <= 1'b0;
              state    <= SETUP;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
`else
            busy  <= 1'b0;
            state <= IDLE;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master with a behavioural SPI memory slave and an expected-result queue.
module tb_spi_master;

  localparam int CD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       rw;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       sclk_pin;
  logic       cs_pin;
  logic       mosi_pin;
  logic       miso_pin;
`ifdef SPI_MASTER_VERIFY_EN
  logic       verify_err;
`endif

  spi_master #(.CLK_DIV(CD), .ADDR_W(7), .DATA_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rw       (rw),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .rdata    (rdata),
    .sclk_pin (sclk_pin),
    .cs_pin   (cs_pin),
    .mosi_pin (mosi_pin),
    .miso_pin (miso_pin)
`ifdef SPI_MASTER_VERIFY_EN
    ,
    .verify_err (verify_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bits;
    logic [7:0]  rdata;
    int          frames;
    logic        verr;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  // Slave and monitor state
  logic [7:0]  mem [128];
  logic        corrupt;
  logic [15:0] rx16 = '0;
  logic [7:0]  rdbyte = '0;
  logic [6:0]  slave_addr = '0;
  int          rises = 0;
  int          cs_low = 0;
  int          high_cnt = 0;
  int          last_gap = 0;
  logic [15:0] frame_bits = '0;
  logic [15:0] first_bits = '0;
  int          frame_rises = 0;
  int          frame_cslow = 0;
  int          frames_since = 0;
  int          done_cnt = 0;
  int          mosi_viol = 0;
  int          done_viol = 0;
  logic        cs_prev = 1'b1;
  logic        sclk_prev = 1'b0;
  logic        mosi_prev = 1'b0;
  logic        done_prev = 1'b0;
  logic [7:0]  cur_rd = '0;

  assign miso_pin = (!cs_pin && rises >= 8 && rises < 16) ? rdbyte[3'(15 - rises)] : 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!cs_pin) begin
      if (cs_prev) begin
        last_gap = high_cnt;
        cs_low   = 0;
        rises    = 0;
        rx16     = '0;
      end
      cs_low++;
      if (sclk_pin && !sclk_prev) begin
        rx16 = {rx16[14:0], mosi_pin};
        rises++;
        if (rises == 8) begin
          slave_addr = rx16[7:1];
          rdbyte     = mem[slave_addr] ^ {7'b0, corrupt};
        end
      end
      if (sclk_pin && sclk_prev && mosi_pin !== mosi_prev) mosi_viol++;
    end else begin
      if (!cs_prev) begin
        frame_bits  = rx16;
        frame_rises = rises;
        frame_cslow = cs_low;
        frames_since++;
        if (frames_since == 1) first_bits = rx16;
        if (rises == 16 && !rx16[8]) mem[rx16[15:9]] = rx16[7:0];
        rises    = 0;
        high_cnt = 0;
      end
      high_cnt++;
    end
    if (reset) frames_since = 0;
    if (done) begin
      done_cnt++;
      if (done_prev) done_viol++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("frame_bits", frame_bits, e.bits);
        check("sclk_rises", frame_rises, 16);
        check("cs_low_cycles", frame_cslow, 34 * CD);
        check("rdata", rdata, e.rdata);
        check("frames_per_done", frames_since, e.frames);
`ifdef SPI_MASTER_VERIFY_EN
        check("verify_err", verify_err, e.verr);
`endif
      end
      frames_since = 0;
    end
    cs_prev   = cs_pin;
    sclk_prev = sclk_pin;
    mosi_prev = mosi_pin;
    done_prev = done;
  end

  task automatic push_exp(input logic r, input logic [6:0] a, input logic [7:0] d,
                          input logic [7:0] rd_exp, input logic verr_exp);
    exp_t e;
    e.bits   = {a, r, r ? 8'h00 : d};
    e.rdata  = r ? rd_exp : cur_rd;
    e.frames = 1;
    e.verr   = 1'b0;
`ifdef SPI_MASTER_VERIFY_EN
    if (!r) begin
      e.bits   = {a, 1'b1, 8'h00};
      e.rdata  = rd_exp;
      e.frames = 2;
      e.verr   = verr_exp;
    end
`endif
    cur_rd = e.rdata;
    sb.push_back(e);
  endtask

  task automatic issue_frame(input logic r, input logic [6:0] a, input logic [7:0] d,
                             input logic [7:0] rd_exp, input logic verr_exp);
    push_exp(r, a, d, rd_exp, verr_exp);
    @(negedge clk); #1;
    start = 1'b1; rw = r; addr = a; wdata = d;
    @(posedge clk); #1;
    // Scramble inputs to prove they were latched.
    start = 1'b0; rw = ~r; addr = ~a; wdata = ~d;
    check("busy_after_accept", busy, 1);
  endtask

  task automatic wait_done(input int tgt);
    int n = 0;
    while (done_cnt < tgt && n < 1000) begin
      @(negedge clk); #1;
      n++;
    end
    check("done_seen", done_cnt >= tgt, 1);
  endtask

  task automatic wait_idle();
    repeat (CD - 1) @(negedge clk);
    check("busy_in_gap", busy, 1);
    @(negedge clk);
    check("busy_after_gap", busy, 0);
  endtask

  initial begin
    int tgt;
    int n;
    reset = 1'b1; start = 1'b0; rw = 1'b0; addr = '0; wdata = '0; corrupt = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_cs", cs_pin, 1);
    check("rst_sclk", sclk_pin, 0);
    check("rst_mosi", mosi_pin, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rdata", rdata, 8'h00);
    @(negedge clk); #1 reset = 1'b0;

    // Write 0x92 to 0x55
    tgt = done_cnt + 1;
    issue_frame(1'b0, 7'h55, 8'h92, 8'h92, 1'b0);
    wait_done(tgt);
    check("write_mosi_bits", first_bits, 16'b1010101_0_10010010);
    wait_idle();

    // Read it back
    tgt = done_cnt + 1;
    issue_frame(1'b1, 7'h55, 8'h00, 8'h92, 1'b0);
    wait_done(tgt);
    wait_idle();

    // Start pulsed mid-frame is ignored
    tgt = done_cnt + 1;
    issue_frame(1'b0, 7'h21, 8'hA5, 8'hA5, 1'b0);
    repeat (40) @(negedge clk);
    #1 start = 1'b1; rw = 1'b1; addr = 7'h7F;
    @(negedge clk); #1 start = 1'b0;
    wait_done(tgt);
    wait_idle();
    repeat (20) @(negedge clk);
    check("no_restart_cs", cs_pin, 1);
    check("no_restart_busy", busy, 0);

    // Start held high: two back-to-back reads
    push_exp(1'b1, 7'h55, 8'h00, 8'h92, 1'b0);
    push_exp(1'b1, 7'h55, 8'h00, 8'h92, 1'b0);
    tgt = done_cnt + 1;
    @(negedge clk); #1 start = 1'b1; rw = 1'b1; addr = 7'h55; wdata = 8'h00;
    wait_done(tgt);
    n = 0;
    while (busy && n < 50) begin @(negedge clk); #1; n++; end
    n = 0;
    while (!busy && n < 50) begin @(negedge clk); #1; n++; end
    check("second_accept", busy, 1);
    start = 1'b0;
    wait_done(tgt + 1);
    check("cs_high_gap", last_gap, CD + 1);
    wait_idle();

    // Reset after the fifth sclk rise
    tgt = done_cnt + 1;
    issue_frame(1'b0, 7'h2A, 8'h11, 8'h11, 1'b0);
    n = 0;
    while (rises < 5 && n < 200) begin @(negedge clk); #1; n++; end
    check("reached_5_rises", rises, 5);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_cs", cs_pin, 1);
    check("midrst_sclk", sclk_pin, 0);
    check("midrst_busy", busy, 0);
    check("midrst_rdata", rdata, 8'h00);
`ifdef SPI_MASTER_VERIFY_EN
    check("midrst_verr", verify_err, 0);
`endif
    sb.delete();
    cur_rd = 8'h00;
    @(negedge clk); #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("after_rst_no_done", done_cnt, tgt - 1);

    tgt = done_cnt + 1;
    issue_frame(1'b0, 7'h2A, 8'h3C, 8'h3C, 1'b0);
    wait_done(tgt);
    wait_idle();
    tgt = done_cnt + 1;
    issue_frame(1'b1, 7'h2A, 8'h00, 8'h3C, 1'b0);
    wait_done(tgt);
    wait_idle();

`ifdef SPI_MASTER_VERIFY_EN
    // Verified writes: matching slave, then a slave that flips bit 0
    tgt = done_cnt + 1;
    issue_frame(1'b0, 7'h12, 8'h92, 8'h92, 1'b0);
    wait_done(tgt);
    wait_idle();
    corrupt = 1'b1;
    tgt = done_cnt + 1;
    issue_frame(1'b0, 7'h13, 8'h92, 8'h93, 1'b1);
    wait_done(tgt);
    wait_idle();
    corrupt = 1'b0;
`endif

    repeat (5) @(negedge clk);
    check("mosi_stable_while_sclk_high", mosi_viol, 0);
    check("done_single_cycle", done_viol, 0);
    check("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
